// File: rtl/esm_issue_select.sv
// ESM issue select: holds instructions from the dependency-analysis stage,
// clears dependency bits as producers complete, and issues one ready slot per
// cycle through a registered valid/ready output register.
module esm_issue_select #(
   parameter int unsigned Instr_word_size = 32,
   parameter int unsigned bs              = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alloc_valid,
   input  logic [$clog2(bs)-1:0]      alloc_index,
   input  logic [Instr_word_size-1:0] alloc_instr,
   input  logic [bs-1:0]              alloc_dep,
   output logic                       alloc_error,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output logic [Instr_word_size-1:0] issue_instr,
   output logic [$clog2(bs)-1:0]      issue_index,
   input  logic                       complete_valid,
   input  logic [$clog2(bs)-1:0]      complete_index,
   output logic [$clog2(bs):0]        occupancy,
   output logic                       full
);

   localparam int unsigned IW = $clog2(bs);
   localparam int unsigned CW = IW + 1;

   // Slot state
   logic [bs-1:0]              valid_q, valid_d;
   logic [bs-1:0]              issued_q, issued_d;
   logic [Instr_word_size-1:0] instr_q [bs];
   logic [Instr_word_size-1:0] instr_d [bs];
   logic [bs-1:0]              dep_q [bs];
   logic [bs-1:0]              dep_d [bs];

   // Issue register and bookkeeping
   logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
   logic                       issue_valid_q, issue_valid_d;
   logic [Instr_word_size-1:0] issue_instr_q, issue_instr_d;
   logic [IW-1:0]              issue_index_q, issue_index_d;
   logic                       alloc_error_q, alloc_error_d;
   logic [CW-1:0]              occupancy_q, occupancy_d;
   logic                       full_q, full_d;

   logic [bs-1:0]              ready;
   logic                       sel_found;
   logic [IW-1:0]              sel_idx;
   logic [IW-1:0]              cand;
   logic                       load;
   logic                       alloc_ok;
   logic                       comp_ok;
   logic [bs-1:0]              alloc_mask;
   logic [bs-1:0]              comp_mask;

   assign load     = ~issue_valid_q | issue_ready;
   assign alloc_ok = alloc_valid & ~valid_q[alloc_index];
   // Completion only counts for a slot that actually went out to execution.
   assign comp_ok  = complete_valid & valid_q[complete_index] & issued_q[complete_index];

   assign alloc_mask = ~(bs'(1) << alloc_index);
   assign comp_mask  = complete_valid ? ~(bs'(1) << complete_index) : '1;

   // Ready vector from registered state only; same-cycle allocs are not visible.
   always_comb begin
      ready = '0;
      for (int i = 0; i < int'(bs); i++) begin
         ready[i] = valid_q[i] & ~issued_q[i] & (dep_q[i] == '0);
      end
   end

   // Rotating-priority scan starting at rr_ptr, wrapping through IW-bit arithmetic.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < int'(bs); k++) begin
         cand = rr_ptr_q + IW'(k);
         if (!sel_found && ready[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Slot next-state: complete clears a column and frees a slot, alloc fills an idle slot.
   always_comb begin
      valid_d  = valid_q;
      issued_d = issued_q;
      instr_d  = instr_q;
      dep_d    = dep_q;
      if (comp_ok) begin
         for (int i = 0; i < int'(bs); i++) begin
            dep_d[i][complete_index] = 1'b0;
         end
         valid_d[complete_index]  = 1'b0;
         issued_d[complete_index] = 1'b0;
      end
      // Alloc needs an IDLE slot and complete needs an ISSUED one, so they never collide.
      if (alloc_ok) begin
         valid_d[alloc_index]  = 1'b1;
         issued_d[alloc_index] = 1'b0;
         instr_d[alloc_index]  = alloc_instr;
         dep_d[alloc_index]    = alloc_dep & alloc_mask & comp_mask;
      end
      if (load && sel_found) begin
         issued_d[sel_idx] = 1'b1;
      end
   end

   // Issue register, round-robin pointer, error pulse and counters next-state.
   always_comb begin
      issue_valid_d = issue_valid_q;
      issue_instr_d = issue_instr_q;
      issue_index_d = issue_index_q;
      rr_ptr_d      = rr_ptr_q;
      if (load) begin
         issue_valid_d = sel_found;
         if (sel_found) begin
            issue_instr_d = instr_q[sel_idx];
            issue_index_d = sel_idx;
            rr_ptr_d      = sel_idx + IW'(1);
         end
      end
      alloc_error_d = alloc_valid & valid_q[alloc_index];
      occupancy_d   = occupancy_q + CW'(alloc_ok) - CW'(comp_ok);
      full_d        = (occupancy_d == CW'(bs));
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q       <= '0;
         issued_q      <= '0;
         for (int i = 0; i < int'(bs); i++) begin
            instr_q[i] <= '0;
            dep_q[i]   <= '0;
         end
         rr_ptr_q      <= '0;
         issue_valid_q <= 1'b0;
         issue_instr_q <= '0;
         issue_index_q <= '0;
         alloc_error_q <= 1'b0;
         occupancy_q   <= '0;
         full_q        <= 1'b0;
      end else begin
         valid_q       <= valid_d;
         issued_q      <= issued_d;
         for (int i = 0; i < int'(bs); i++) begin
            instr_q[i] <= instr_d[i];
            dep_q[i]   <= dep_d[i];
         end
         rr_ptr_q      <= rr_ptr_d;
         issue_valid_q <= issue_valid_d;
         issue_instr_q <= issue_instr_d;
         issue_index_q <= issue_index_d;
         alloc_error_q <= alloc_error_d;
         occupancy_q   <= occupancy_d;
         full_q        <= full_d;
      end
   end

   assign alloc_error = alloc_error_q;
   assign issue_valid = issue_valid_q;
   assign issue_instr = issue_instr_q;
   assign issue_index = issue_index_q;
   assign occupancy   = occupancy_q;
   assign full        = full_q;

endmodule

// File: tb/tb_esm_issue_select.sv
// Directed bench for esm_issue_select with hand-computed expectations.
module tb_esm_issue_select;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_valid;
   logic [3:0]  alloc_index;
   logic [31:0] alloc_instr;
   logic [15:0] alloc_dep;
   logic        alloc_error;
   logic        issue_valid;
   logic        issue_ready;
   logic [31:0] issue_instr;
   logic [3:0]  issue_index;
   logic        complete_valid;
   logic [3:0]  complete_index;
   logic [4:0]  occupancy;
   logic        full;

   int n_checks = 0;
   int n_errors = 0;

   esm_issue_select #(
      .Instr_word_size(32),
      .bs             (16)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .alloc_valid   (alloc_valid),
      .alloc_index   (alloc_index),
      .alloc_instr   (alloc_instr),
      .alloc_dep     (alloc_dep),
      .alloc_error   (alloc_error),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_instr   (issue_instr),
      .issue_index   (issue_index),
      .complete_valid(complete_valid),
      .complete_index(complete_index),
      .occupancy     (occupancy),
      .full          (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; sample and drive 1 time unit after it.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input logic [3:0] idx, input logic [31:0] ins, input logic [15:0] dep);
      alloc_valid = 1'b1;
      alloc_index = idx;
      alloc_instr = ins;
      alloc_dep   = dep;
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic do_complete(input logic [3:0] idx);
      complete_valid = 1'b1;
      complete_index = idx;
      tick();
      complete_valid = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      alloc_valid    = 1'b0;
      alloc_index    = '0;
      alloc_instr    = '0;
      alloc_dep      = '0;
      issue_ready    = 1'b0;
      complete_valid = 1'b0;
      complete_index = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_issue_valid", issue_valid, 0);
      check("rst_issue_instr", issue_instr, 0);
      check("rst_issue_index", issue_index, 0);
      check("rst_alloc_error", alloc_error, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_full", full, 0);

      // Single alloc, issue two edges later
      do_alloc(4'd3, 32'h00A00093, 16'h0000);
      check("t1_not_yet", issue_valid, 0);
      check("t1_occ", occupancy, 1);
      tick();
      check("t1_valid", issue_valid, 1);
      check("t1_index", issue_index, 3);
      check("t1_instr", issue_instr, 32'h00A00093);
      issue_ready = 1'b1;
      tick();
      check("t1_drained", issue_valid, 0);
      do_complete(4'd3);
      check("t1_occ_done", occupancy, 0);

      // Dependency chain: slot 1 waits on slot 0
      do_alloc(4'd0, 32'h11110000, 16'h0000);
      do_alloc(4'd1, 32'h11110001, 16'h0001);
      check("t2_issue0_valid", issue_valid, 1);
      check("t2_issue0_index", issue_index, 0);
      check("t2_occ2", occupancy, 2);
      tick();
      check("t2_slot1_held", issue_valid, 0);
      do_complete(4'd0);
      check("t2_not_same_cycle", issue_valid, 0);
      check("t2_occ1", occupancy, 1);
      tick();
      check("t2_issue1_valid", issue_valid, 1);
      check("t2_issue1_index", issue_index, 1);
      check("t2_issue1_instr", issue_instr, 32'h11110001);
      tick();
      do_complete(4'd1);
      check("t2_occ0", occupancy, 0);

      // Backpressure with slots 2 and 5
      issue_ready = 1'b0;
      do_alloc(4'd2, 32'h000000A2, 16'h0000);
      do_alloc(4'd5, 32'h000000A5, 16'h0000);
      check("t3_hold_valid", issue_valid, 1);
      check("t3_hold_index", issue_index, 2);
      for (int c = 0; c < 5; c++) begin
         tick();
         check("t3_stable_index", issue_index, 2);
         check("t3_stable_instr", issue_instr, 32'h000000A2);
      end
      issue_ready = 1'b1;
      tick();
      check("t3_next_valid", issue_valid, 1);
      check("t3_next_index", issue_index, 5);
      check("t3_next_instr", issue_instr, 32'h000000A5);
      tick();
      check("t3_empty", issue_valid, 0);
      do_complete(4'd2);
      do_complete(4'd5);
      check("t3_occ0", occupancy, 0);

      // Rotating priority: park slot 14 so rr_ptr=15, then ready 0, 1, 15
      do_alloc(4'd14, 32'h0000000E, 16'h0000);
      tick();
      issue_ready = 1'b0;
      check("t4_park_index", issue_index, 14);
      do_alloc(4'd0, 32'h00000F00, 16'h0000);
      do_alloc(4'd1, 32'h00000F01, 16'h0000);
      do_alloc(4'd15, 32'h00000F0F, 16'h0000);
      check("t4_still_parked", issue_index, 14);
      issue_ready = 1'b1;
      tick();
      check("t4_first", issue_index, 15);
      tick();
      check("t4_second", issue_index, 0);
      tick();
      check("t4_third", issue_index, 1);
      tick();
      check("t4_empty", issue_valid, 0);
      do_complete(4'd14);
      do_complete(4'd15);
      do_complete(4'd0);
      do_complete(4'd1);
      check("t4_occ0", occupancy, 0);

      // Errors: alloc onto a WAIT slot, complete on WAIT and IDLE slots
      do_alloc(4'd4, 32'h00000044, 16'h0100);
      check("t5_no_err", alloc_error, 0);
      do_alloc(4'd4, 32'h00000055, 16'h0000);
      check("t5_err_pulse", alloc_error, 1);
      check("t5_err_occ", occupancy, 1);
      tick();
      check("t5_err_cleared", alloc_error, 0);
      check("t5_dep_kept", issue_valid, 0);
      do_complete(4'd4);
      check("t5_wait_cmp_occ", occupancy, 1);
      do_complete(4'd8);
      check("t5_idle_cmp_occ", occupancy, 1);
      tick();
      check("t5_idle_cmp_dep", issue_valid, 0);
      do_alloc(4'd8, 32'h00000088, 16'h0000);
      check("t5_occ2", occupancy, 2);
      tick();
      check("t5_prod_index", issue_index, 8);
      tick();
      check("t5_prod_gone", issue_valid, 0);
      do_complete(4'd8);
      tick();
      check("t5_cons_valid", issue_valid, 1);
      check("t5_cons_index", issue_index, 4);
      check("t5_cons_instr", issue_instr, 32'h00000044);
      tick();
      do_complete(4'd4);
      check("t5_occ0", occupancy, 0);

      // Fill every slot, then reset mid-handshake
      issue_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         do_alloc(4'(i), 32'hC0DE0000 | 32'(i), 16'h0000);
      end
      check("t6_occ16", occupancy, 16);
      check("t6_full", full, 1);
      check("t6_pending", issue_valid, 1);
      rst         = 1'b1;
      issue_ready = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_valid", issue_valid, 0);
      check("t6_rst_occ", occupancy, 0);
      check("t6_rst_full", full, 0);
      check("t6_rst_index", issue_index, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
